piso_left_right_hs_nb: RTL

Parameterized parallel-in serial-out word shifter with valid/ready handshakes on both sides: accepts a frame of PISO_WIDTH words in one transfer and emits them one word per accepted output beat, in left or right order chosen per frame. It is the transmit end of the left/right serial word path. Its OUT/OUT_VALID stream feeds a serial-in stage one word per clock, and its PIN side is fed by frame-building logic.

---
 rtl/piso_left_right_hs_nb_pkg.sv | 11 +
 rtl/piso_word_array.sv | 45 ++++
 rtl/piso_left_right_hs_nb.sv | 84 ++++++++
 3 files changed

// File: rtl/piso_left_right_hs_nb_pkg.sv
// Shared encodings for the left/right PISO word shifter.
// Single-bit FSM state and frame-order constants.
package piso_left_right_hs_nb_pkg;

    localparam logic DIR_RIGHT = 1'b0;
    localparam logic DIR_LEFT  = 1'b1;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;

endpackage

// File: rtl/piso_word_array.sv
// Word register array: parallel load, or one-word shift toward high (left) or low (right) index with zero fill.
// One cycle per load/shift; holds when neither control is asserted.
module piso_word_array
    import piso_left_right_hs_nb_pkg::*;
#(
    parameter int BUS_WIDTH  = 8,
    parameter int PISO_WIDTH = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            load,
    input  logic                            shift,
    input  logic                            dir,
    input  logic [BUS_WIDTH*PISO_WIDTH-1:0] pin,
    output logic [BUS_WIDTH*PISO_WIDTH-1:0] words
);

    logic [BUS_WIDTH*PISO_WIDTH-1:0] words_q;
    logic [BUS_WIDTH*PISO_WIDTH-1:0] words_d;

    // Word k sits at bits k*BUS_WIDTH, so a whole-vector shift by one word moves every index and zero-fills.
    always_comb begin
        words_d = words_q;
        if (load) begin
            words_d = pin;
        end else if (shift) begin
            if (dir == DIR_LEFT) begin
                words_d = words_q << BUS_WIDTH;
            end else begin
                words_d = words_q >> BUS_WIDTH;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            words_q <= '0;
        end else begin
            words_q <= words_d;
        end
    end

    assign words = words_q;

endmodule

// File: rtl/piso_left_right_hs_nb.sv
// Parallel-in serial-out word shifter with valid/ready on both sides; frame order chosen per frame by DIR.
// First word the cycle after load; consumer stalls (OUT_READY=0) hold the current word; IN_READY low while shifting.
module piso_left_right_hs_nb
    import piso_left_right_hs_nb_pkg::*;
#(
    parameter int BUS_WIDTH  = 8,
    parameter int PISO_WIDTH = 4
) (
    input  logic                            CLK,
    input  logic                            RST,
    input  logic [BUS_WIDTH*PISO_WIDTH-1:0] PIN,
    input  logic                            DIR,
    input  logic                            IN_VALID,
    output logic                            IN_READY,
    output logic [BUS_WIDTH-1:0]            OUT,
    output logic                            OUT_VALID,
    input  logic                            OUT_READY,
    output logic                            OUT_LAST
);

    localparam int CNT_W = $clog2(PISO_WIDTH + 1);

    logic [0:0]                      state_q, state_d;
    logic [CNT_W-1:0]                cnt_q, cnt_d;
    logic                            dir_q, dir_d;
    logic                            load, beat, last;
    logic [BUS_WIDTH*PISO_WIDTH-1:0] words;
    logic [BUS_WIDTH-1:0]            head;

    assign load = (state_q == ST_IDLE) && IN_VALID;
    assign beat = (state_q == ST_SHIFT) && OUT_READY;
    assign last = (cnt_q == CNT_W'(1));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dir_d   = dir_q;
        if (load) begin
            state_d = ST_SHIFT;
            cnt_d   = CNT_W'(PISO_WIDTH);
            dir_d   = DIR;
        end else if (beat) begin
            cnt_d = cnt_q - CNT_W'(1);
            if (last) begin
                state_d = ST_IDLE;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            dir_q   <= DIR_RIGHT;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
        end
    end

    piso_word_array #(
        .BUS_WIDTH  (BUS_WIDTH),
        .PISO_WIDTH (PISO_WIDTH)
    ) u_array (
        .clk   (CLK),
        .rst   (RST),
        .load  (load),
        .shift (beat),
        .dir   (dir_q),
        .pin   (PIN),
        .words (words)
    );

    // The word leaving next is always at the end the array shifts toward.
    assign head = (dir_q == DIR_LEFT) ? words[(PISO_WIDTH-1)*BUS_WIDTH +: BUS_WIDTH]
                                      : words[BUS_WIDTH-1:0];

    assign IN_READY  = (state_q == ST_IDLE);
    assign OUT_VALID = (state_q == ST_SHIFT);
    assign OUT       = OUT_VALID ? head : '0;
    assign OUT_LAST  = OUT_VALID && last;

endmodule
